adc_sample_ctrl: RTL

//  Upstream sampling stage of the ultrasonic capture path: paces ADC conversions at a fixed rate,

---
 rtl/adc_sample_ctrl_pkg.sv | 17 +
 rtl/adc_sample_ctrl_spi_rx.sv | 84 ++++++++
 rtl/adc_sample_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/adc_sample_ctrl_pkg.sv
// Shared types and helpers for the ADC sampling controller.
package adc_sample_ctrl_pkg;

    // Frame sequencer states.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StConv  = 2'd1,
        StShift = 2'd2,
        StStore = 2'd3
    } state_e;

    // Bits needed to hold a counter whose largest value is 'terminal' (at least 1).
    function automatic int unsigned cnt_width(input int unsigned terminal);
        return (terminal < 2) ? 1 : $clog2(terminal + 1);
    endfunction

endpackage

// File: rtl/adc_sample_ctrl_spi_rx.sv
// Receive-only SPI engine: generates SCK, counts bits and shifts MISO in MSB first.
// A start is only taken while idle; done pulses for one cycle during the final SCK high phase.
module adc_sample_ctrl_spi_rx
    import adc_sample_ctrl_pkg::*;
#(
    parameter int unsigned SCK_HALF  = 4,
    parameter int unsigned DATA_BITS = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic                 miso_i,
    output logic                 sck_o,
    output logic                 done_o,
    output logic [DATA_BITS-1:0] data_o
);

    localparam int unsigned PhW  = cnt_width(2 * SCK_HALF - 1);
    localparam int unsigned BitW = cnt_width(DATA_BITS - 1);
    localparam logic [PhW-1:0]  PhRise  = PhW'(SCK_HALF - 1);
    localparam logic [PhW-1:0]  PhLast  = PhW'(2 * SCK_HALF - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(DATA_BITS - 1);

    logic                 busy_q, busy_d;
    logic [PhW-1:0]       ph_q, ph_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;

    // Phase/bit counting and shift register next state; abort wins over everything.
    always_comb begin
        busy_d  = busy_q;
        ph_d    = ph_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        if (abort_i) begin
            busy_d = 1'b0;
            ph_d   = '0;
            bit_d  = '0;
        end else if (!busy_q) begin
            if (start_i) begin
                busy_d = 1'b1;
                ph_d   = '0;
                bit_d  = '0;
            end
        end else begin
            // This edge is the one where SCK goes high, so MISO is captured here.
            if (ph_q == PhRise) begin
                shreg_d = {shreg_q[DATA_BITS-2:0], miso_i};
            end
            if (ph_q == PhLast) begin
                ph_d = '0;
                if (bit_q == BitLast) begin
                    busy_d = 1'b0;
                    bit_d  = '0;
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end else begin
                ph_d = ph_q + 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q  <= 1'b0;
            ph_q    <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
        end else begin
            busy_q  <= busy_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
        end
    end

    assign sck_o  = busy_q & (ph_q > PhRise);
    assign done_o = busy_q & (ph_q == PhLast) & (bit_q == BitLast);
    assign data_o = shreg_q;

endmodule

// File: rtl/adc_sample_ctrl.sv
// ADC sampling controller: paces conversions, reads each result over SPI and strobes it into
// the capture FIFO. Sampling halts on FIFO overflow until ENA is dropped and raised again.
module adc_sample_ctrl
    import adc_sample_ctrl_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV  = 256,
    parameter int unsigned CONV_CYCLES = 40,
    parameter int unsigned SCK_HALF    = 4,
    parameter int unsigned DATA_BITS   = 16
) (
    input  logic                 SYS_CLK,
    input  logic                 RST,
    input  logic                 ENA,
    input  logic                 FIFO_FULL,
    input  logic                 MISO,
    output logic                 SCK,
    output logic                 CSbar,
    output logic                 CONVST,
    output logic [DATA_BITS-1:0] SAMPLE,
    output logic                 SAMPLE_WR,
    output logic                 OVERFLOW,
    output logic                 MISSED,
    output logic [15:0]          SAMPLE_CNT
);

    // Cycles from tick to write strobe; the tick period must leave room for one full frame.
    localparam int unsigned FrameLat = CONV_CYCLES + 2 * SCK_HALF * DATA_BITS + 2;

    if (SAMPLE_DIV < FrameLat + 1 || CONV_CYCLES < 1 || SCK_HALF < 1 || DATA_BITS < 2)
    begin : g_bad_cfg
        $error("adc_sample_ctrl: SAMPLE_DIV shorter than one frame or zero-sized timing");
    end

    localparam int unsigned TickW = cnt_width(SAMPLE_DIV - 1);
    localparam int unsigned ConvW = cnt_width(CONV_CYCLES - 1);
    localparam logic [TickW-1:0] TickLast = TickW'(SAMPLE_DIV - 1);
    localparam logic [ConvW-1:0] ConvLast = ConvW'(CONV_CYCLES - 1);

    state_e               state_q, state_d;
    logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [ConvW-1:0]     conv_cnt_q, conv_cnt_d;
    logic [DATA_BITS-1:0] sample_q, sample_d;
    logic                 sample_wr_q, sample_wr_d;
    logic                 overflow_q, overflow_d;
    logic                 missed_q, missed_d;
    logic [15:0]          sample_cnt_q, sample_cnt_d;

    logic                 tick;
    logic                 spi_start;
    logic                 spi_abort;
    logic                 spi_done;
    logic [DATA_BITS-1:0] spi_data;

    // Tick is suppressed while disabled or after an overflow, so neither can launch a frame.
    assign tick = ENA & ~overflow_q & (tick_cnt_q == TickLast);

    adc_sample_ctrl_spi_rx #(
        .SCK_HALF  (SCK_HALF),
        .DATA_BITS (DATA_BITS)
    ) u_spi_rx (
        .clk_i   (SYS_CLK),
        .rst_i   (RST),
        .start_i (spi_start),
        .abort_i (spi_abort),
        .miso_i  (MISO),
        .sck_o   (SCK),
        .done_o  (spi_done),
        .data_o  (spi_data)
    );

    // Tick divider, frame sequencing, sticky flags and sample counter next state.
    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        conv_cnt_d   = conv_cnt_q;
        sample_d     = sample_q;
        sample_wr_d  = 1'b0;
        overflow_d   = overflow_q;
        missed_d     = missed_q;
        sample_cnt_d = sample_cnt_q;
        spi_start    = 1'b0;
        spi_abort    = ~ENA;

        if (!ENA) begin
            tick_cnt_d = '0;
        end else if (!overflow_q) begin
            tick_cnt_d = (tick_cnt_q == TickLast) ? '0 : tick_cnt_q + 1'b1;
        end

        if (!ENA) begin
            // Disabling aborts any frame in flight and clears the sticky flags.
            state_d    = StIdle;
            overflow_d = 1'b0;
            missed_d   = 1'b0;
        end else begin
            if (tick && state_q != StIdle) begin
                missed_d = 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (tick) begin
                        state_d    = StConv;
                        conv_cnt_d = '0;
                    end
                end
                StConv: begin
                    if (conv_cnt_q == ConvLast) begin
                        state_d   = StShift;
                        spi_start = 1'b1;
                    end else begin
                        conv_cnt_d = conv_cnt_q + 1'b1;
                    end
                end
                StShift: begin
                    if (spi_done) begin
                        state_d = StStore;
                    end
                end
                StStore: begin
                    state_d = StIdle;
                    if (FIFO_FULL) begin
                        overflow_d = 1'b1;
                    end else begin
                        sample_d     = spi_data;
                        sample_wr_d  = 1'b1;
                        sample_cnt_d = sample_cnt_q + 16'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State register.
    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            state_q      <= StIdle;
            tick_cnt_q   <= '0;
            conv_cnt_q   <= '0;
            sample_q     <= '0;
            sample_wr_q  <= 1'b0;
            overflow_q   <= 1'b0;
            missed_q     <= 1'b0;
            sample_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            conv_cnt_q   <= conv_cnt_d;
            sample_q     <= sample_d;
            sample_wr_q  <= sample_wr_d;
            overflow_q   <= overflow_d;
            missed_q     <= missed_d;
            sample_cnt_q <= sample_cnt_d;
        end
    end

    assign CONVST     = (state_q == StConv);
    assign CSbar      = (state_q != StShift);
    assign SAMPLE     = sample_q;
    assign SAMPLE_WR  = sample_wr_q;
    assign OVERFLOW   = overflow_q;
    assign MISSED     = missed_q;
    assign SAMPLE_CNT = sample_cnt_q;

endmodule
